// File: rtl/serial_vector_packer_pkg.sv
// -----------------------------------------------------------------------------
// serial_vector_packer_pkg
// Shared definitions for the serial vector packer and its reduction-OR helper.
//   state_e           : packer FSM states (COLLECT, HOLD)
//   DEFAULT_VEC_WIDTH : vector width of the downstream reduction-OR consumer
//   count_width()     : bits needed to hold a bit count in 0..width
// -----------------------------------------------------------------------------
package serial_vector_packer_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    localparam int DEFAULT_VEC_WIDTH = 5;

    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_vector_packer_bitwise_or.sv
// -----------------------------------------------------------------------------
// serial_vector_packer_bitwise_or
// Reduction-OR of a WIDTH-bit vector (same function as the Bitwise_Or consumer).
// Ports:
//   vec : input vector
//   any : 1 when any bit of vec is set
// -----------------------------------------------------------------------------
module serial_vector_packer_bitwise_or #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] vec,
    output logic             any
);

    assign any = |vec;

endmodule

// File: rtl/serial_vector_packer.sv
// -----------------------------------------------------------------------------
// serial_vector_packer
// Collects a serial bit stream (valid/ready) into WIDTH-bit vectors and offers
// each completed vector downstream (valid/ready) with its registered
// reduction-OR flag.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   flush      : (SERIAL_PACK_FLUSH_EN only) emit a partial vector early
//   in_valid   : upstream bit valid
//   in_bit     : serial data bit
//   in_ready   : packer accepts a bit this cycle (COLLECT)
//   out_valid  : out_vec holds a complete vector (HOLD)
//   out_ready  : downstream takes the vector this cycle
//   out_vec    : assembled vector
//   out_any    : OR of out_vec, registered
//   out_count  : bits collected so far
// Build option: define SERIAL_PACK_FLUSH_EN to add the flush input.
// -----------------------------------------------------------------------------
module serial_vector_packer
    import serial_vector_packer_pkg::*;
#(
    parameter  int WIDTH     = DEFAULT_VEC_WIDTH,
    parameter  bit LSB_FIRST = 1'b1,
    localparam int CW        = count_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SERIAL_PACK_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_vec,
    output logic             out_any,
    output logic [CW-1:0]    out_count
);

    localparam logic [0:0] ST_COLLECT = COLLECT;
    localparam logic [0:0] ST_HOLD    = HOLD;

    logic [0:0]       state;
    logic             accept;
    logic             full;
    logic             do_flush;
    logic             go_hold;
    logic [WIDTH-1:0] vec_acc;
    logic [CW-1:0]    count_inc;
    logic             any_next;

    assign in_ready  = (state == ST_COLLECT);
    assign out_valid = (state == ST_HOLD);

    // NOTE: every signal gets a default at the top of always_comb so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        accept    = in_ready && in_valid;
        vec_acc   = out_vec;
        count_inc = out_count + CW'(1);
        if (accept) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (LSB_FIRST ? (i == int'(out_count))
                              : (i == WIDTH - 1 - int'(out_count))) begin
                    vec_acc[i] = in_bit;
                end
            end
        end
        full     = accept && (out_count == CW'(WIDTH - 1));
`ifdef SERIAL_PACK_FLUSH_EN
        // A bit accepted alongside flush is already folded into vec_acc.
        do_flush = flush && in_ready && (out_count != '0);
`else
        do_flush = 1'b0;
`endif
        go_hold  = full || do_flush;
    end

    // The flag is computed from the next-state vector so that it is valid in
    // the same cycle out_valid rises.
    if (WIDTH == DEFAULT_VEC_WIDTH) begin : g_or_block
        serial_vector_packer_bitwise_or #(
            .WIDTH (DEFAULT_VEC_WIDTH)
        ) u_bitwise_or (
            .vec (vec_acc),
            .any (any_next)
        );
    end else begin : g_or_inline
        assign any_next = |vec_acc;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the vector register is reset (not left to fill) so a
            // discarded partial vector can never leak into the next one.
            state     <= ST_COLLECT;
            out_count <= '0;
            out_vec   <= '0;
            out_any   <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    out_vec <= vec_acc;
                    out_any <= any_next;
                    if (accept) begin
                        out_count <= count_inc;
                    end
                    if (go_hold) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state     <= ST_COLLECT;
                        out_count <= '0;
                        out_vec   <= '0;
                        out_any   <= 1'b0;
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

endmodule
